// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered UART transmitter: byte FIFO feeding an 8N1 (or 8E1) serialiser
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   write_en_i   single-cycle write strobe; pushes data_i when ready_o=1
//   data_i       byte to transmit
//   tx_o         registered serial output, idles high
//   ready_o      FIFO not full
//   busy_o       frame in progress or FIFO non-empty (registered)
//   fifo_count_o current FIFO occupancy
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit (8E1).

module uart_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        write_en_i,
  input  logic [7:0]                  data_i,
  output logic                        tx_o,
  output logic                        ready_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

  localparam logic [31:0]      BIT_LAST = 32'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic bit_done;
  logic push;
  logic pop;

  // Fullness is judged on the registered count, so a full FIFO refuses a
  // write even on a cycle where the FSM is popping.
  assign push     = write_en_i && (count_q != FULL);
  assign bit_done = (clk_cnt_q == BIT_LAST);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = bit_done ? 32'd0 : clk_cnt_q + 32'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = 32'd0;
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = 3'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_done) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit so queued bytes go out
          // without an idle gap.
          if (count_q != '0) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_cnt_d = 3'd0;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = 32'd0;
        bit_cnt_d = 3'd0;
      end
    endcase

    // The pin is registered, so its next value follows the next state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[bit_cnt_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^shift_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= 32'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign ready_o      = (count_q != FULL);
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx

`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       write_en_i;
  logic [7:0] data_i;
  logic       tx_o;
  logic       ready_o;
  logic       busy_o;
  logic [2:0] fifo_count_o;

  int n_checks = 0;
  int n_fail   = 0;
  int frames   = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic [7:0] data;
    bit         accept;
    int         count;
    bit         ready;
  } vec_t;

  uart_tx #(
    .CLK_FREQ   (1000000),
    .BAUD_RATE  (100000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_en_i   (write_en_i),
    .data_i       (data_i),
    .tx_o         (tx_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait n falling edges; give up early once reset is seen.
  task automatic wait_clks(input int n, inout bit ab);
    if (ab) return;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rst_n) begin
        ab = 1'b1;
        return;
      end
    end
  endtask

  // Counts edges until busy_o falls, starting from the current edge.
  task automatic busy_len(output int k);
    k = 0;
    while (busy_o && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic drain(input string name);
    int k;
    busy_len(k);
    check(name, (k < 2000), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Line monitor: decodes frames mid-bit and checks them against the scoreboard.
  initial begin : mon
    bit         ab;
    logic [7:0] b;
    logic       s0, s1, p;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_o === 1'b0) begin
        ab = 1'b0;
        b  = '0;
        p  = 1'b0;
        s1 = 1'b0;
        wait_clks(4, ab);
        s0 = tx_o;
        for (int i = 0; i < 8; i++) begin
          wait_clks(CPB, ab);
          b[i] = tx_o;
        end
`ifdef UART_TX_PARITY_EN
        wait_clks(CPB, ab);
        p = tx_o;
`endif
        wait_clks(CPB, ab);
        s1 = tx_o;
        if (!ab) begin
          frames++;
          check("start_bit", s0, 0);
          check("stop_bit", s1, 1);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", p, ^b);
`endif
          check("frame_expected", (sb.size() > 0), 1);
          if (sb.size() > 0) check("rx_byte", b, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    int   k;
    int   f0;
    logic tx_a, tx_b, v9;

    rst_n      = 1'b0;
    write_en_i = 1'b0;
    data_i     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_o, 1);
    check("rst_ready", ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_count", fifo_count_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single byte
    write_en_i = 1'b1; data_i = 8'h55; sb.push_back(8'h55);
    @(posedge clk); #1;
    write_en_i = 1'b0;
    check("t1_tx_at_write_edge", tx_o, 1);
    check("t1_count_after_write", fifo_count_o, 1);
    check("t1_busy_after_write", busy_o, 1);
    @(posedge clk); #1;
    check("t1_tx_start", tx_o, 0);
    check("t1_count_after_pop", fifo_count_o, 0);
    busy_len(k);
    check("t1_busy_len", k, FRAME);
    repeat (3) @(posedge clk); #1;
    check("t1_sb_empty", sb.size(), 0);

    // Back-to-back
    write_en_i = 1'b1; data_i = 8'hA5; sb.push_back(8'hA5);
    @(posedge clk); #1;
    data_i = 8'h3C; sb.push_back(8'h3C);
    @(posedge clk); #1;
    write_en_i = 1'b0;
    check("t2_count_collide", fifo_count_o, 1);
    k = 0; tx_a = 1'b0; tx_b = 1'b1;
    while (busy_o && k < 2000) begin
      @(posedge clk); #1;
      k++;
      if (k == FRAME - 1) tx_a = tx_o;
      if (k == FRAME)     tx_b = tx_o;
    end
    check("t2_busy_len", k, 2 * FRAME);
    check("t2_stop_before_second", tx_a, 1);
    check("t2_no_idle_gap", tx_b, 0);
    repeat (3) @(posedge clk); #1;
    check("t2_sb_empty", sb.size(), 0);

    // Full FIFO, table driven
    tbl[0] = '{8'h01, 1'b1, 1, 1'b1};
    tbl[1] = '{8'h02, 1'b1, 1, 1'b1};
    tbl[2] = '{8'h03, 1'b1, 2, 1'b1};
    tbl[3] = '{8'h04, 1'b1, 3, 1'b1};
    tbl[4] = '{8'h05, 1'b1, 4, 1'b0};
    tbl[5] = '{8'h06, 1'b0, 4, 1'b0};
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      write_en_i = 1'b1;
      data_i     = tbl[i].data;
      if (tbl[i].accept) sb.push_back(tbl[i].data);
      @(posedge clk); #1;
      check($sformatf("t3_count_%0d", i), fifo_count_o, tbl[i].count);
      check($sformatf("t3_ready_%0d", i), ready_o, tbl[i].ready);
    end
    write_en_i = 1'b0;
    drain("t3_drain");
    check("t3_frames", frames - f0, 5);
    check("t3_sb_empty", sb.size(), 0);

    // Parity / frame length
    write_en_i = 1'b1; data_i = 8'h07; sb.push_back(8'h07);
    @(posedge clk); #1;
    write_en_i = 1'b0;
    @(posedge clk); #1;
    k = 0; v9 = 1'b0;
    while (busy_o && k < 2000) begin
      @(posedge clk); #1;
      k++;
      if (k == 9 * CPB + 5) v9 = tx_o;
    end
    check("t4_frame_len", k, FRAME);
    check("t4_bit9_high", v9, 1);
    repeat (3) @(posedge clk); #1;
    check("t4_sb_empty", sb.size(), 0);

    // Reset during data bit 3
    write_en_i = 1'b1; data_i = 8'hFF; sb.push_back(8'hFF);
    @(posedge clk); #1;
    write_en_i = 1'b0;
    @(posedge clk); #1;
    repeat (44) @(posedge clk);
    #1;
    check("t5_busy_before_reset", busy_o, 1);
    rst_n = 1'b0;
    #1;
    check("t5_tx_reset", tx_o, 1);
    check("t5_count_reset", fifo_count_o, 0);
    check("t5_busy_reset", busy_o, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t5_tx_idle_after", tx_o, 1);
    f0 = frames;
    write_en_i = 1'b1; data_i = 8'h81; sb.push_back(8'h81);
    @(posedge clk); #1;
    write_en_i = 1'b0;
    @(posedge clk); #1;
    check("t5_tx_start", tx_o, 0);
    busy_len(k);
    check("t5_frame_len", k, FRAME);
    repeat (3) @(posedge clk); #1;
    check("t5_frames", frames - f0, 1);
    check("t5_sb_empty", sb.size(), 0);

    // Push on the pop edge at the end of a frame
    write_en_i = 1'b1; data_i = 8'h11; sb.push_back(8'h11);
    @(posedge clk); #1;
    write_en_i = 1'b0;
    @(posedge clk); #1;
    check("t6_tx_start", tx_o, 0);
    write_en_i = 1'b1; data_i = 8'h22; sb.push_back(8'h22);
    @(posedge clk); #1;
    write_en_i = 1'b0;
    check("t6_count_queued", fifo_count_o, 1);
    repeat (FRAME - 2) @(posedge clk);
    #1;
    check("t6_count_before_pop", fifo_count_o, 1);
    write_en_i = 1'b1; data_i = 8'h33; sb.push_back(8'h33);
    @(posedge clk); #1;
    write_en_i = 1'b0;
    check("t6_count_collision", fifo_count_o, 1);
    check("t6_next_start", tx_o, 0);
    drain("t6_drain");
    check("t6_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
